// File: rtl/int_to_fp.sv
// -----------------------------------------------------------------------------
// int_to_fp -- multi-cycle signed integer to IEEE-754 single-precision converter.
//
// The integer magnitude is normalised by a shift-left loop that moves one bit
// per cycle. It is then rounded to nearest, ties to even, and packed as
// {sign, exponent, fraction}. Integer inputs never produce overflow, NaN or
// denormal results, so none of those cases are handled.
//
// Ports:
//   clk     in   1         system clock, rising edge
//   reset   in   1         synchronous, active-high; aborts any conversion
//   start   in   1         one-cycle request, accepted only in IDLE or DONE
//   dataa   in   IN_WIDTH  signed two's-complement operand, latched on start
//   result  out  32        IEEE single result, valid while done = 1
//   done    out  1         result valid; held until next accepted start/reset
//   busy    out  1         conversion in progress (ABS, NORM, ROUND)
//
// Latency, counting the start-sampling edge as edge 1: done rises after
// edge 2 for a zero input. Otherwise it rises after edge lz+4, where lz is
// the number of leading zeros of the magnitude.
// -----------------------------------------------------------------------------
module int_to_fp #(
    parameter int IN_WIDTH = 32  // only 32 is a specified configuration
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] dataa,
    output logic [31:0]         result,
    output logic                done,
    output logic                busy
);

    // Exponent of a magnitude whose MSB is already at bit IN_WIDTH-1.
    localparam logic [7:0] EXP_INIT = 8'(127 + IN_WIDTH - 1);

    // Fraction, guard and sticky positions, measured from the top of the
    // normalised magnitude.
    localparam int FRAC_MSB  = IN_WIDTH - 2;
    localparam int GUARD_BIT = IN_WIDTH - 25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_e;

    state_e              state_q;
    logic                sign_q;
    logic [IN_WIDTH-1:0] mag_q;
    logic [7:0]          exp_q;
    logic [31:0]         result_q;
    logic                done_q;
    logic                busy_q;

    // Rounding datapath. This logic is combinational from the normalised
    // magnitude and is used only in ROUND.
    logic [22:0] frac;
    logic        guard;
    logic        sticky;
    logic        round_up;
    logic [23:0] frac_sum_d;   // carry-out in bit 23 marks mantissa overflow
    logic [22:0] frac_d;
    logic [7:0]  exp_d;

    // Two's-complement magnitude of the operand. The most negative input
    // maps onto itself, and reading that value as unsigned is the correct
    // magnitude.
    logic [IN_WIDTH-1:0] abs_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block can infer a latch.
        abs_d      = dataa[IN_WIDTH-1] ? (~dataa + 1'b1) : dataa;

        frac       = mag_q[FRAC_MSB -: 23];
        guard      = mag_q[GUARD_BIT];
        sticky     = |mag_q[GUARD_BIT-1:0];
        round_up   = guard && (sticky || frac[0]);
        frac_sum_d = {1'b0, frac} + {23'd0, round_up};

        frac_d     = frac_sum_d[22:0];
        exp_d      = exp_q;
        if (frac_sum_d[23]) begin
            // All-ones fraction rolled over: mantissa becomes 1.0, bump exp.
            frac_d = 23'd0;
            exp_d  = exp_q + 8'd1;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            exp_q    <= 8'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sign_q  <= dataa[IN_WIDTH-1];
                        mag_q   <= abs_d;
                        exp_q   <= EXP_INIT;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_ABS;
                    end
                end

                S_ABS: begin
                    if (mag_q == '0) begin
                        // Zero has no leading one; emit positive zero directly.
                        result_q <= 32'd0;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        state_q  <= S_NORM;
                    end
                end

                S_NORM: begin
                    if (mag_q[IN_WIDTH-1]) begin
                        state_q <= S_ROUND;
                    end else begin
                        mag_q <= {mag_q[IN_WIDTH-2:0], 1'b0};
                        exp_q <= exp_q - 8'd1;
                    end
                end

                S_ROUND: begin
                    exp_q    <= exp_d;
                    result_q <= {sign_q, exp_d, frac_d};
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_DONE;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_int_to_fp.sv
// -----------------------------------------------------------------------------
// tb_int_to_fp -- scoreboard bench for int_to_fp.
//
// The stimulus side pushes each expected result and its expected latency into
// a queue. The monitor runs on the falling clock edge and pops one entry each
// time done rises. The reference model converts with plain integer arithmetic:
// it finds the top set bit, then divides and rounds using the remainder.
// -----------------------------------------------------------------------------
module tb_int_to_fp;

    typedef struct {
        logic [31:0] din;
        logic [31:0] res;
        int          lat;
        int          start_edge;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic done_prev = 1'b0;

    int_to_fp #(.IN_WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .dataa  (dataa),
        .result (result),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    // Reference conversion: round to nearest, ties to even, on the exact
    // integer magnitude.
    function automatic logic [31:0] ref_conv(input logic [31:0] d,
                                             output int lat);
        longint m, q, rem, half, e;
        int     p, sh;
        logic   s;
        s = d[31];
        m = longint'(d);
        if (s) m = 64'sh1_0000_0000 - m;
        if (m == 0) begin
            lat = 2;
            return 32'd0;
        end
        p = 31;
        while (((m >> p) & 1) == 0) p--;
        lat = (31 - p) + 4;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            rem  = m & ((64'sd1 << sh) - 1);
            half = 64'sd1 << (sh - 1);
            if (rem > half || (rem == half && (q & 1) == 1)) q++;
        end
        e = 127 + p;
        if (q == (64'sd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        return {s, e[7:0], q[22:0]};
    endfunction

    // Monitor: compare on every rising edge of done; check invariants each cycle.
    always @(negedge clk) begin
        if (busy && done) check("busy_done_exclusive", {busy, done}, 2'b00);
        if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check($sformatf("result(din=0x%08h)", e.din), result, e.res);
                check($sformatf("latency(din=0x%08h)", e.din),
                      32'(cyc - e.start_edge + 1), 32'(e.lat));
            end
        end
        done_prev = done;
    end

    // Issue one accepted start, expecting the DUT to be in IDLE or DONE.
    task automatic convert(input logic [31:0] d);
        exp_t e;
        int   lat;
        @(negedge clk);
        e.din        = d;
        e.res        = ref_conv(d, lat);
        e.lat        = lat;
        e.start_edge = cyc + 1;
        sb_q.push_back(e);
        start = 1'b1;
        dataa = d;
        @(negedge clk);
        start = 1'b0;
        dataa = $urandom;  // later operand changes must not matter
        check("done_cleared_after_start", {31'd0, done}, 32'd0);
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // Wait, with a bounded budget, until the monitor has consumed every entry.
    task automatic drain();
        int i;
        for (i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            check("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] directed[8];
        directed = '{32'd1, 32'd3, 32'hffff_ffff, 32'd0,
                     32'h0100_0001, 32'h0100_0003, 32'h7fff_ffff, 32'h8000_0000};

        reset = 1'b1;
        start = 1'b0;
        dataa = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_result", result, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Directed values: small, negative, zero, rounding ties, extremes.
        foreach (directed[i]) begin
            convert(directed[i]);
            drain();
        end

        // A start pulse while busy must be ignored.
        convert(32'd6);
        @(negedge clk);
        check("busy_before_ignored_start", {31'd0, busy}, 32'd1);
        start = 1'b1;
        dataa = 32'd5;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("result_held_in_done", result, 32'h40c0_0000);
        check("done_held", {31'd0, done}, 32'd1);
        convert(32'd5);
        drain();

        // Reset in the middle of a conversion aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1;
        dataa = 32'd1;
        @(negedge clk);           // edge 1 has sampled start
        start = 1'b0;
        repeat (8) @(negedge clk);  // edges 2..9
        reset = 1'b1;
        @(negedge clk);           // edge 10 samples reset
        reset = 1'b0;
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);  // the monitor flags any stray done
        check("abort_stays_idle", {30'd0, busy, done}, 32'd0);
        convert(32'd2);
        drain();

        // Randomised operands drawn from several magnitude classes.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] d;
            case ($urandom_range(0, 4))
                0: d = $urandom;
                1: d = 32'($urandom_range(0, 300));
                2: d = -32'($urandom_range(0, 300));
                3: d = $urandom >> $urandom_range(0, 31);
                default: d = ($urandom | 32'h0000_00ff) << $urandom_range(0, 8);
            endcase
            convert(d);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench ends even if the flow stalls.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: cycle %0d reached time limit", cyc);
        $fatal(1, "timeout");
    end

endmodule
